mem_access_unit: RTL

Sequential memory-stage controller between the pipeline's execute stage and the data-memory bus. It accepts one load or store request at a time and drives word-aligned bus reads and writes. Sub-word stores use a read-modify-write sequence. All byte/half extraction and merging goes through the existing `LoadStore` combinational block, and each request ends in a single-cycle response to the core.

---
 rtl/mem_access_unit_pkg.sv | 28 ++
 rtl/mem_access_unit_load_store.sv | 67 ++++++
 rtl/mem_access_unit.sv | 125 ++++++++++++
 3 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory-stage controller: access lengths, FSM states
// and the request alignment rule.
package mem_access_unit_pkg;

    localparam int unsigned DATA_WIDTH = 32;

    localparam logic [1:0] LOAD_STORE_BYTE = 2'd0;
    localparam logic [1:0] LOAD_STORE_HALF = 2'd1;
    localparam logic [1:0] LOAD_STORE_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } mauState_t;

    // A half may straddle bytes 0..2 but not cross the word; length 3 is illegal.
    function automatic logic isAligned(input logic [1:0] len, input logic [1:0] offset);
        case (len)
            LOAD_STORE_BYTE: return 1'b1;
            LOAD_STORE_HALF: return offset != 2'd3;
            LOAD_STORE_WORD: return offset == 2'd0;
            default:         return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_load_store.sv
// LoadStore: combinational byte/half extraction for loads and merge for stores
// within one 32-bit word.
module LoadStore
    import mem_access_unit_pkg::*;
(
    input  logic [DATA_WIDTH-1:0] dataIn,
    input  logic [1:0]            offset,
    input  logic [1:0]            length,
    input  logic                  signExtend,
    input  logic [DATA_WIDTH-1:0] writeDataIn,
    output logic [DATA_WIDTH-1:0] readDataOut,
    output logic [DATA_WIDTH-1:0] writeDataOut
);

    logic [7:0]  byteSel;
    logic [15:0] halfSel;

    always_comb begin
        byteSel      = 8'h00;
        halfSel      = 16'h0000;
        readDataOut  = '0;
        writeDataOut = dataIn;

        case (offset)
            2'd0:    byteSel = dataIn[7:0];
            2'd1:    byteSel = dataIn[15:8];
            2'd2:    byteSel = dataIn[23:16];
            default: byteSel = dataIn[31:24];
        endcase

        // Offset 3 is rejected upstream for halves; it aliases offset 2 here.
        case (offset)
            2'd0:    halfSel = dataIn[15:0];
            2'd1:    halfSel = dataIn[23:8];
            default: halfSel = dataIn[31:16];
        endcase

        case (length)
            LOAD_STORE_BYTE: begin
                readDataOut = {{24{signExtend & byteSel[7]}}, byteSel};
                case (offset)
                    2'd0:    writeDataOut[7:0]   = writeDataIn[7:0];
                    2'd1:    writeDataOut[15:8]  = writeDataIn[7:0];
                    2'd2:    writeDataOut[23:16] = writeDataIn[7:0];
                    default: writeDataOut[31:24] = writeDataIn[7:0];
                endcase
            end
            LOAD_STORE_HALF: begin
                readDataOut = {{16{signExtend & halfSel[15]}}, halfSel};
                case (offset)
                    2'd0:    writeDataOut[15:0]  = writeDataIn[15:0];
                    2'd1:    writeDataOut[23:8]  = writeDataIn[15:0];
                    default: writeDataOut[31:16] = writeDataIn[15:0];
                endcase
            end
            LOAD_STORE_WORD: begin
                readDataOut  = dataIn;
                writeDataOut = writeDataIn;
            end
            default: begin
                readDataOut  = '0;
                writeDataOut = dataIn;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage controller: one load/store at a time, word-aligned bus accesses,
// read-modify-write for sub-word stores, single-cycle response to the core.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  reqValid,
    output logic                  reqReady,
    input  logic                  reqWrite,
    input  logic [ADDR_WIDTH-1:0] reqAddr,
    input  logic [1:0]            reqLen,
    input  logic                  reqSignExtend,
    input  logic [DATA_WIDTH-1:0] reqWriteData,
    output logic                  respValid,
    output logic [DATA_WIDTH-1:0] respData,
    output logic                  respError,
    output logic [ADDR_WIDTH-1:0] memAddr,
    output logic                  memRead,
    output logic                  memWrite,
    output logic [DATA_WIDTH-1:0] memWriteData,
    input  logic [DATA_WIDTH-1:0] memReadData,
    input  logic                  memReady
);

    mauState_t             state;
    mauState_t             stateNext;
    logic [ADDR_WIDTH-1:0] addrQ;
    logic [1:0]            lenQ;
    logic                  signQ;
    logic                  writeQ;
    logic [DATA_WIDTH-1:0] wdataQ;
    logic [DATA_WIDTH-1:0] dataQ;
    logic                  respLoad;
    logic                  accept;
    logic                  reqErr;
    logic [DATA_WIDTH-1:0] lsReadData;

    assign accept = reqValid && reqReady;
    assign reqErr = !isAligned(reqLen, reqAddr[1:0]);

    // Next-state decode.
    always_comb begin
        stateNext = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (reqErr) begin
                        stateNext = ST_RESP;
                    end else if (!reqWrite || (reqLen != LOAD_STORE_WORD)) begin
                        stateNext = ST_READ;
                    end else begin
                        stateNext = ST_WRITE;
                    end
                end
            end
            ST_READ: begin
                if (memReady) begin
                    stateNext = writeQ ? ST_WRITE : ST_RESP;
                end
            end
            ST_WRITE: begin
                if (memReady) begin
                    stateNext = ST_RESP;
                end
            end
            ST_RESP: stateNext = ST_IDLE;
            default: stateNext = ST_IDLE;
        endcase
    end

    // State, request latches and registered strobes/handshakes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            reqReady  <= 1'b0;
            memRead   <= 1'b0;
            memWrite  <= 1'b0;
            respValid <= 1'b0;
            respError <= 1'b0;
            respLoad  <= 1'b0;
            addrQ     <= '0;
            lenQ      <= LOAD_STORE_BYTE;
            signQ     <= 1'b0;
            writeQ    <= 1'b0;
            wdataQ    <= '0;
            dataQ     <= '0;
        end else begin
            state     <= stateNext;
            reqReady  <= (stateNext == ST_IDLE);
            memRead   <= (stateNext == ST_READ);
            memWrite  <= (stateNext == ST_WRITE);
            respValid <= (stateNext == ST_RESP);
            // Only the IDLE -> RESP path is an error; only a load reaches RESP from READ.
            respError <= (stateNext == ST_RESP) && (state == ST_IDLE);
            respLoad  <= (stateNext == ST_RESP) && (state != ST_IDLE) && !writeQ;
            if (accept) begin
                addrQ  <= reqAddr;
                lenQ   <= reqLen;
                signQ  <= reqSignExtend;
                writeQ <= reqWrite;
                wdataQ <= reqWriteData;
            end
            if ((state == ST_READ) && memReady) begin
                dataQ <= memReadData;
            end
        end
    end

    LoadStore u_loadStore (
        .dataIn       (dataQ),
        .offset       (addrQ[1:0]),
        .length       (lenQ),
        .signExtend   (signQ),
        .writeDataIn  (wdataQ),
        .readDataOut  (lsReadData),
        .writeDataOut (memWriteData)
    );

    assign memAddr  = {addrQ[ADDR_WIDTH-1:2], 2'b00};
    assign respData = respLoad ? lsReadData : '0;

endmodule
